// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, one digit per clock.
// Optional invalid-digit flag: define BCD_INVALID_DIGIT_CHECK_EN.
module bcd_serial_addsub #(
   parameter int DIGITS = 4,
   parameter int CW     = $clog2(DIGITS) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                sub,
   input  logic                cin,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] result,
   output logic                cout,
   output logic                err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic                sub_q, sub_d, carry_q, carry_d;
   logic                cout_q, cout_d, busy_q, busy_d, done_q, done_d;

   logic [3:0] a_dig, b_dig, bd, dout;
   logic [4:0] s;
   logic       cy, last;

   // Digit mux written as a compare loop so the counter never indexes out of range.
   always_comb begin
      a_dig = 4'd0;
      b_dig = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (cnt_q == CW'(i)) begin
            a_dig = a_q[4*i +: 4];
            b_dig = b_q[4*i +: 4];
         end
      end
      bd = sub_q ? (4'd9 - b_dig) : b_dig;
      s  = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry_q};
      if (s > 5'd9) begin
         dout = s[3:0] + 4'd6;
         cy   = 1'b1;
      end else begin
         dout = s[3:0];
         cy   = 1'b0;
      end
      last = (cnt_q == CW'(DIGITS - 1));
   end

`ifdef BCD_INVALID_DIGIT_CHECK_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      busy_d   = busy_q;
      done_d   = done_q;
`ifdef BCD_INVALID_DIGIT_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub;
               carry_d = sub ? ~cin : cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CALC;
`ifdef BCD_INVALID_DIGIT_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_CALC: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (cnt_q == CW'(i)) result_d[4*i +: 4] = dout;
            end
            carry_d = cy;
            cnt_d   = cnt_q + 1'b1;
`ifdef BCD_INVALID_DIGIT_CHECK_EN
            // Raw b digit is checked, not its nine's complement.
            err_d   = err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
`endif
            if (last) begin
               cout_d  = cy;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef BCD_INVALID_DIGIT_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Multi-digit packed-BCD adder/subtractor. Processes one decimal digit per clock, least-significant digit first, through a single registered digit adder.
- Generalises the single-digit combinational BCD adder to DIGITS digits and adds a subtract mode (nine's complement), a start/done handshake and an optional invalid-digit flag.
- Sits in the arithmetic-circuit library as the building block for decimal counters, calculators and display datapaths.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result (>=1).
- CW, $clog2(DIGITS)+1, digit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- cin  input  1  carry-in (add) / borrow-in (sub); captured with start.
- a  input  4*DIGITS  packed BCD operand A; digit i = a[4i+3:4i].
- b  input  4*DIGITS  packed BCD operand B.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result, cout and err are valid.
- result  output  4*DIGITS  packed BCD result.
- cout  output  1  add: decimal carry-out. Sub: 1 = no borrow (a >= b+cin), 0 = borrow; result is then the ten's complement.
- err  output  1  invalid-digit flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, cout=0, err=0, counter=0, operand registers cleared. An operation in flight is abandoned with no done pulse.
- FSM states: IDLE, CALC, DONE.
  - IDLE: on a clock edge with start=1, capture a, b, sub, cin into registers; initial carry = sub ? ~cin : cin; counter=0; go to CALC; busy=1. With start=0, stay in IDLE.
  - CALC: each edge processes digit[counter]:
    - bd = sub ? (9 - b_digit) : b_digit.
    - s = a_digit + bd + carry (5-bit).
    - If s > 9: out digit = (s + 6)[3:0], carry = 1. Otherwise: out digit = s[3:0], carry = 0.
    - Write the out digit into result at position counter; increment counter.
    - On the edge that processes digit DIGITS-1: cout = final carry, busy=0, done=1, go to DONE.
  - DONE: next edge sets done=0 and goes to IDLE. start is ignored in this state.
- Latency: done goes high DIGITS edges after the edge that sampled start. Throughput is one operation per DIGITS+2 cycles.
- start is ignored while busy or in DONE; captured operands are unaffected by input changes after capture.
- result is updated digit by digit during CALC and is valid only while done=1. It holds its final value until the next accepted start.
- Operand digits must be 0-9. With a non-BCD digit, the digit path uses the same rule on 5-bit s; the output is not decimal-correct and is not checked beyond err.
- DIGITS=1: CALC lasts one cycle; behaviour is otherwise identical.

Optional Feature:
- Macro: BCD_INVALID_DIGIT_CHECK_EN.
- Defined: during CALC, err is OR-accumulated with (a_digit > 9) | (b_digit > 9) for each processed digit. err is cleared on accepted start and held through DONE until the next start. The raw b digit is checked, not its complement.
- Undefined: err tied to 0; no comparison logic is synthesised.

Test Plan:
- DIGITS=4, add, a=0x1234, b=0x5678, cin=0 -> done 4 edges after start; result=0x6912, cout=0, err=0.
- Add, a=0x9999, b=0x0001, cin=0 -> result=0x0000, cout=1. Repeat with b=0x0000, cin=1 -> same result.
- Sub, a=0x5000, b=0x1234, cin=0 -> result=0x3766, cout=1. Sub, a=0x1234, b=0x5000 -> result=0x6234, cout=0.
- Pulse start again on cycles 2 and 4 of a running operation, with different operands -> ignored; first result unchanged; exactly one done pulse.
- Assert rst for 1 cycle during CALC (counter=2) -> all outputs 0 immediately, no done. Then a=0x0005, b=0x0005 -> result=0x0010, cout=0.
- With BCD_INVALID_DIGIT_CHECK_EN: a=0x00A0, b=0x0001 -> err=1 at done. Next valid operation -> err=0. Without the macro -> err stays 0.
